// File: rtl/gowin_phase_step_responder.sv
// gowin_phase_step_responder
// Responder side of the DDR3 write-leveling phase-step handshake for Gowin
// rPLLs. Asynchronous step requests are synchronized, edge-detected and
// turned into single +/-1 changes of the PSDA phase word. A settle window
// follows each change, and one extra request may be queued during it.
// DUTYDA tracks PSDA with a constant +8 offset (50% duty).

module gowin_phase_step_responder #(
    parameter int PHASE_INIT    = 12,
    parameter int SETTLE_CYCLES = 64,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phase_step,
    input  logic       phase_updn,
    output logic       phase_done,
    output logic [3:0] psda,
    output logic [3:0] duty_da,
    output logic       step_dropped
);

    localparam int              CNT_W       = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]      PSDA_RST    = PHASE_INIT[3:0];
    localparam logic [3:0]      DUTY_RST    = PSDA_RST + 4'd8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    // ------------------------------------------------------------------
    // Front end: synchronizers, edge register, arming, registered event
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] step_sync_q, step_sync_d;
    logic [SYNC_STAGES-1:0] updn_sync_q, updn_sync_d;
    logic [SYNC_STAGES-1:0] fill_q,      fill_d;
    logic                   step_prev_q, step_prev_d;
    logic                   armed_q,     armed_d;
    logic                   evt_q,       evt_d;
    logic                   evt_dir_q,   evt_dir_d;

    logic                   step_s;
    logic                   updn_s;
    logic                   step_valid;

    // ------------------------------------------------------------------
    // Step engine state
    // ------------------------------------------------------------------
    logic [0:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             pending_q,  pending_d;
    logic             pend_dir_q, pend_dir_d;
    logic [3:0]       psda_q,     psda_d;
    logic [3:0]       duty_q,     duty_d;
    logic             done_q,     done_d;
    logic             dropped_q,  dropped_d;

    function automatic logic [3:0] step_word(input logic [3:0] w, input logic up);
        return up ? (w + 4'd1) : (w - 4'd1);
    endfunction

    assign step_s     = step_sync_q[SYNC_STAGES-1];
    assign updn_s     = updn_sync_q[SYNC_STAGES-1];
    assign step_valid = fill_q[SYNC_STAGES-1];

    // Synchronize requests, detect qualified rising edges of phase_step
    always_comb begin
        step_sync_d = {step_sync_q[SYNC_STAGES-2:0], phase_step};
        updn_sync_d = {updn_sync_q[SYNC_STAGES-2:0], phase_updn};
        // The chain resets to 0, so its output only reflects the real input
        // once it has been refilled; arming on the reset zeros would turn a
        // request held high across reset release into a spurious step.
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        step_prev_d = step_s;
        armed_d     = armed_q | (step_valid & ~step_s);
        evt_d       = step_s & ~step_prev_q & armed_q;
        evt_dir_d   = updn_s;
    end

    // Front-end registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            updn_sync_q <= '0;
            fill_q      <= '0;
            step_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            evt_q       <= 1'b0;
            evt_dir_q   <= 1'b0;
        end else begin
            step_sync_q <= step_sync_d;
            updn_sync_q <= updn_sync_d;
            fill_q      <= fill_d;
            step_prev_q <= step_prev_d;
            armed_q     <= armed_d;
            evt_q       <= evt_d;
            evt_dir_q   <= evt_dir_d;
        end
    end

    // Apply steps, run the settle window, queue or drop extra requests
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        pend_dir_d = pend_dir_q;
        psda_d     = psda_q;
        dropped_d  = dropped_q;

        case (state_q)
            ST_IDLE: begin
                if (evt_q) begin
                    psda_d  = step_word(psda_q, evt_dir_q);
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    if (pending_q) begin
                        psda_d    = step_word(psda_q, pend_dir_q);
                        cnt_d     = SETTLE_LOAD;
                        pending_d = 1'b0;
                        if (evt_q) begin
                            dropped_d = 1'b1;
                        end
                    end else if (evt_q) begin
                        // Request arriving on the last settle cycle is queued
                        // and consumed at the same edge.
                        psda_d = step_word(psda_q, evt_dir_q);
                        cnt_d  = SETTLE_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (evt_q) begin
                        if (pending_q) begin
                            dropped_d = 1'b1;
                        end else begin
                            pending_d  = 1'b1;
                            pend_dir_d = evt_dir_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        duty_d = psda_d + 4'd8;
        done_d = (state_d == ST_IDLE);
    end

    // Step engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            pend_dir_q <= 1'b0;
            psda_q     <= PSDA_RST;
            duty_q     <= DUTY_RST;
            done_q     <= 1'b1;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            pend_dir_q <= pend_dir_d;
            psda_q     <= psda_d;
            duty_q     <= duty_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
        end
    end

    assign phase_done   = done_q;
    assign psda         = psda_q;
    assign duty_da      = duty_q;
    assign step_dropped = dropped_q;

endmodule

// File: tb/tb_gowin_phase_step_responder.sv
// tb_gowin_phase_step_responder
// Directed scenarios plus randomized step traffic for the phase-step
// responder. A transaction-level model predicts every output each cycle.

module tb_gowin_phase_step_responder;

    localparam int SYNC   = 2;
    localparam int SETTLE = 64;
    localparam int INIT   = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       phase_step = 1'b0;
    logic       phase_updn = 1'b0;
    logic       phase_done;
    logic [3:0] psda;
    logic [3:0] duty_da;
    logic       step_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    gowin_phase_step_responder #(
        .PHASE_INIT   (INIT),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_step  (phase_step),
        .phase_updn  (phase_updn),
        .phase_done  (phase_done),
        .psda        (psda),
        .duty_da     (duty_da),
        .step_dropped(step_dropped)
    );

    always #5 clk = ~clk;

    // Single point for every comparison
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_psda;
    bit m_busy;
    int m_end;
    bit m_pend;
    bit m_pdir;
    bit m_drop;
    bit m_prev_valid;
    bit m_prev_in;
    int m_cyc;
    bit ev_pipe [SYNC+1];
    bit dir_pipe[SYNC+1];

    function automatic int stepped(input int w, input bit up);
        return up ? (w + 1) % 16 : (w + 15) % 16;
    endfunction

    task automatic model_reset();
        m_psda = INIT;
        m_busy = 0;
        m_end = 0;
        m_pend = 0;
        m_pdir = 0;
        m_drop = 0;
        m_prev_valid = 0;
        m_prev_in = 0;
        for (int i = 0; i <= SYNC; i++) begin
            ev_pipe[i]  = 0;
            dir_pipe[i] = 0;
        end
    endtask

    // One clock edge with rst_n high: requests seen rising at edge k act at k+SYNC+1
    task automatic model_edge();
        bit ev;
        bit dir;
        m_cyc++;
        ev  = ev_pipe[SYNC];
        dir = dir_pipe[SYNC];
        for (int i = SYNC; i > 0; i--) begin
            ev_pipe[i]  = ev_pipe[i-1];
            dir_pipe[i] = dir_pipe[i-1];
        end
        ev_pipe[0]  = m_prev_valid && !m_prev_in && phase_step;
        dir_pipe[0] = phase_updn;
        m_prev_in    = phase_step;
        m_prev_valid = 1;

        if (m_busy) begin
            if (ev) begin
                if (m_pend) m_drop = 1;
                else begin
                    m_pend = 1;
                    m_pdir = dir;
                end
            end
            if (m_cyc == m_end) begin
                if (m_pend) begin
                    m_psda = stepped(m_psda, m_pdir);
                    m_end  = m_cyc + SETTLE;
                    m_pend = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end else if (ev) begin
            m_psda = stepped(m_psda, dir);
            m_busy = 1;
            m_end  = m_cyc + SETTLE;
        end
    endtask

    initial model_reset();
    always @(negedge rst_n) model_reset();

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        if (rst_n) model_edge();
        #1;
        check_val("psda", psda, m_psda);
        check_val("duty_da", duty_da, (m_psda + 8) % 16);
        check_val("phase_done", phase_done, !m_busy);
        check_val("step_dropped", step_dropped, m_drop);
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 1..3 rises of one direction, 4-cycle highs at offsets 0,10,20
    task automatic burst(input bit dir, input int n_rises, input int start, input int exp_low);
        int low_cnt;
        int applied;
        int expf;
        low_cnt = 0;
        phase_updn = dir;
        wait_cyc(SYNC + 2);
        phase_step = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 4 || i == 14 || i == 24) phase_step = 1'b0;
            if ((i == 10 && n_rises > 1) || (i == 20 && n_rises > 2)) phase_step = 1'b1;
            if (i == SYNC) check_val("lat_hold", psda, start);
            if (i == SYNC + 1) check_val("lat_step", psda, stepped(start, dir));
            if (!phase_done) low_cnt++;
            else if (low_cnt > 0) break;
        end
        phase_step = 1'b0;
        check_val("low_run", low_cnt, exp_low);
        applied = (n_rises > 2) ? 2 : n_rises;
        expf = start;
        for (int j = 0; j < applied; j++) expf = stepped(expf, dir);
        check_val("final_psda", psda, expf);
        check_val("final_duty", duty_da, (expf + 8) % 16);
    endtask

    initial begin
        // reset state
        wait_cyc(3);
        check_val("rst_psda", psda, 12);
        check_val("rst_duty", duty_da, 4);
        check_val("rst_done", phase_done, 1);
        check_val("rst_drop", step_dropped, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        // single up, wrap 15->0, then down
        burst(1, 1, 12, SETTLE);
        burst(1, 1, 13, SETTLE);
        burst(1, 1, 14, SETTLE);
        burst(1, 1, 15, SETTLE);
        check_val("wrap_psda", psda, 0);
        check_val("wrap_duty", duty_da, 8);
        burst(0, 1, 0, SETTLE);
        check_val("down_psda", psda, 15);
        check_val("down_duty", duty_da, 7);

        // chained and dropped requests
        burst(1, 2, 15, 2 * SETTLE);
        check_val("chain_drop", step_dropped, 0);
        burst(1, 3, 1, 2 * SETTLE);
        check_val("third_drop", step_dropped, 1);

        // request held high across reset release
        rst_n = 1'b0;
        #1;
        check_val("rst2_psda", psda, 12);
        check_val("rst2_drop", step_dropped, 0);
        phase_step = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(10);
        phase_step = 1'b0;
        wait_cyc(20);
        check_val("held_psda", psda, 12);
        check_val("held_done", phase_done, 1);
        burst(1, 1, 12, SETTLE);

        // reset 20 cycles into settle with a pending step
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(5);
        phase_updn = 1'b1;
        wait_cyc(SYNC + 2);
        phase_step = 1'b1;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i == 4 || i == 14) phase_step = 1'b0;
            if (i == 10) phase_step = 1'b1;
        end
        check_val("mid_busy", phase_done, 0);
        rst_n = 1'b0;
        #1;
        check_val("mid_psda", psda, 12);
        check_val("mid_duty", duty_da, 4);
        check_val("mid_done", phase_done, 1);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(200);
        check_val("post_psda", psda, 12);
        check_val("post_done", phase_done, 1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            phase_updn = 1'($urandom_range(0, 1));
            wait_cyc($urandom_range(SYNC + 2, 140));
            phase_step = 1'b1;
            wait_cyc($urandom_range(SYNC + 1, 12));
            phase_step = 1'b0;
        end
        wait_cyc(3 * SETTLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
